// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and extended load returns onto the
// register file's single write port, with a 2-entry load buffer and anti-starvation.
module writeback_unit #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_data,
  input  logic [4:0]  hz_rs1,
  input  logic [4:0]  hz_rs2,
  output logic        hz_stall,
  output logic        WR_EN,
  output logic [4:0]  write_select,
  output logic [31:0] data_in
);

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] data;
  } ld_entry_t;

  ld_entry_t   fifo_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_sel_q, wr_sel_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        empty, full, starve;
  logic        alu_fire, push, pop;
  logic [1:0]  entry_valid;
  ld_entry_t   head, incoming;

  function automatic logic [31:0] extend_load(input logic [2:0]  funct3,
                                              input logic [1:0]  addr_lo,
                                              input logic [31:0] word);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    case (addr_lo)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  return {{24{lane_b[7]}}, lane_b};
      3'b001:  return {{16{lane_h[15]}}, lane_h};
      3'b100:  return {24'd0, lane_b};
      3'b101:  return {16'd0, lane_h};
      default: return word;
    endcase
  endfunction

  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'd2);
  assign starve    = (starve_cnt_q >= STARVE_LIMIT) && !empty;
  assign alu_ready = !starve;
  // Full is judged on current occupancy only, so a same-cycle pop never frees a slot early.
  assign ld_ready  = !full;
  assign alu_fire  = alu_valid && alu_ready;
  assign pop       = !alu_fire && !empty;
  assign push      = ld_valid && ld_ready;
  assign head      = fifo_q[rd_ptr_q];
  assign incoming  = '{rd: ld_rd, funct3: ld_funct3, addr_lo: ld_addr_lo, data: ld_data};

  assign entry_valid = full  ? 2'b11 :
                       empty ? 2'b00 :
                       (rd_ptr_q ? 2'b10 : 2'b01);

  always_comb begin
    hz_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (entry_valid[i] && fifo_q[i].rd != 5'd0 &&
          (fifo_q[i].rd == hz_rs1 || fifo_q[i].rd == hz_rs2)) begin
        hz_stall = 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_cnt_d = '0;
    wr_en_d      = 1'b0;
    wr_sel_d     = wr_sel_q;
    wr_data_d    = wr_data_q;
    if (alu_fire) begin
      starve_cnt_d = starve_cnt_q;
      if (!empty && starve_cnt_q != 4'hF) starve_cnt_d = starve_cnt_q + 4'd1;
      wr_en_d   = (alu_rd != 5'd0);
      wr_sel_d  = alu_rd;
      wr_data_d = alu_result;
    end else if (pop) begin
      wr_en_d   = (head.rd != 5'd0);
      wr_sel_d  = head.rd;
      wr_data_d = extend_load(head.funct3, head.addr_lo, head.data);
    end
  end

  // NOTE: buffer storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= incoming;
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      wr_en_q      <= 1'b0;
      wr_sel_q     <= '0;
      wr_data_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= !wr_ptr_q;
      if (pop)  rd_ptr_q <= !rd_ptr_q;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_sel_q     <= wr_sel_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign WR_EN        = wr_en_q;
  assign write_select = wr_sel_q;
  assign data_in      = wr_data_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_writeback_unit;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_data;
  logic [4:0]  hz_rs1, hz_rs2;
  logic        hz_stall;
  logic        WR_EN;
  logic [4:0]  write_select;
  logic [31:0] data_in;

  writeback_unit #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .ld_data(ld_data),
    .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_stall(hz_stall),
    .WR_EN(WR_EN), .write_select(write_select), .data_in(data_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] d;
  } ld_t;

  ld_t         q[$];
  int          m_cnt = 0;
  logic        e_en;
  logic [4:0]  e_sel;
  logic [31:0] e_data;

  function automatic logic [31:0] m_ext(input ld_t e);
    logic [31:0] w;
    case (e.f3)
      3'd0, 3'd4: begin
        w = (e.d >> (8 * int'(e.lo))) & 32'hFF;
        if (e.f3 == 3'd0 && w >= 32'h80) w = w | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        w = (e.d >> (16 * int'(e.lo / 2))) & 32'hFFFF;
        if (e.f3 == 3'd1 && w >= 32'h8000) w = w | 32'hFFFF_0000;
      end
      default: w = e.d;
    endcase
    return w;
  endfunction

  function automatic bit m_starve();
    return (m_cnt >= SM) && (q.size() > 0);
  endfunction

  function automatic bit m_hazard();
    bit h = 1'b0;
    foreach (q[i]) if (q[i].rd != 0 && (q[i].rd == hz_rs1 || q[i].rd == hz_rs2)) h = 1'b1;
    return h;
  endfunction

  always @(posedge clk) begin
    bit  alu_w, pop_w, push_w;
    ld_t h;
    if (rst) begin
      q.delete();
      m_cnt  = 0;
      e_en   = 1'b0;
      e_sel  = '0;
      e_data = '0;
    end else begin
      alu_w  = alu_valid && !m_starve();
      pop_w  = !alu_w && q.size() > 0;
      push_w = ld_valid && q.size() < 2;
      if (alu_w) begin
        e_en = (alu_rd != 0); e_sel = alu_rd; e_data = alu_result;
        if (q.size() > 0) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      end else if (pop_w) begin
        h = q.pop_front();
        e_en = (h.rd != 0); e_sel = h.rd; e_data = m_ext(h);
        m_cnt = 0;
      end else begin
        e_en = 1'b0;
        m_cnt = 0;
      end
      if (push_w) q.push_back('{rd: ld_rd, f3: ld_funct3, lo: ld_addr_lo, d: ld_data});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_wr_en",     32'(WR_EN),        32'(e_en));
      check("cmp_write_sel", 32'(write_select), 32'(e_sel));
      check("cmp_data_in",   data_in,           e_data);
      check("cmp_alu_ready", 32'(alu_ready),    32'(!m_starve()));
      check("cmp_ld_ready",  32'(ld_ready),     32'(q.size() < 2));
      check("cmp_hz_stall",  32'(hz_stall),     32'(m_hazard()));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0; ld_data = 0;
    hz_rs1 = 0; hz_rs2 = 0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] exp;
  } ext_vec_t;

  ext_vec_t ext_vecs[5] = '{
    '{3'b000, 2'd0, 32'h0000_007F},
    '{3'b000, 2'd1, 32'hFFFF_FFF2},
    '{3'b100, 2'd3, 32'h0000_0080},
    '{3'b001, 2'd2, 32'hFFFF_8001},
    '{3'b101, 2'd0, 32'h0000_F27F}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  waits;
    bit  accepted;
    idle_inputs();
    rst = 1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 0;
    check("reset_wr_en",     32'(WR_EN),        32'd0);
    check("reset_write_sel", 32'(write_select), 32'd0);
    check("reset_data_in",   data_in,           32'd0);
    check("reset_alu_ready", 32'(alu_ready),    32'd1);
    check("reset_ld_ready",  32'(ld_ready),     32'd1);

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_result = 32'hDEAD_BEEF;
    tick();
    alu_valid = 0;
    check("alu_wr_en",     32'(WR_EN),        32'd1);
    check("alu_write_sel", 32'(write_select), 32'd5);
    check("alu_data_in",   data_in,           32'hDEAD_BEEF);
    check("alu_ready_hi",  32'(alu_ready),    32'd1);
    tick();
    check("idle_wr_en", 32'(WR_EN), 32'd0);
    check("idle_hold",  data_in,    32'hDEAD_BEEF);

    // Load extension
    foreach (ext_vecs[i]) begin
      ld_valid = 1; ld_rd = 5'(10 + i); ld_funct3 = ext_vecs[i].f3;
      ld_addr_lo = ext_vecs[i].lo; ld_data = 32'h8001_F27F;
      tick();
      ld_valid = 0;
      check("ld_not_yet", 32'(WR_EN), 32'd0);
      tick();
      check("ld_ext_data", data_in,           ext_vecs[i].exp);
      check("ld_ext_sel",  32'(write_select), 32'(10 + i));
      check("ld_ext_en",   32'(WR_EN),        32'd1);
    end

    // rd=0 suppression
    alu_valid = 1; alu_rd = 0; alu_result = 32'h1234_5678;
    ld_valid = 1; ld_rd = 0; ld_funct3 = 3'b010; ld_data = 32'hCAFE_0000;
    tick();
    alu_valid = 0; ld_valid = 0;
    check("rd0_alu_en", 32'(WR_EN), 32'd0);
    tick();
    check("rd0_ld_en",  32'(WR_EN), 32'd0);
    tick();

    // FIFO full, third load held until a pop frees a slot
    alu_valid = 1; alu_rd = 1; alu_result = 32'h111;
    ld_valid = 1; ld_rd = 2; ld_funct3 = 3'b010; ld_data = 32'hA;
    tick();
    ld_rd = 3; ld_data = 32'hB;
    tick();
    check("full_ld_ready", 32'(ld_ready), 32'd0);
    ld_rd = 4; ld_data = 32'hC;
    waits = 0; accepted = 0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (ld_ready) accepted = 1;
      else waits++;
      tick();
    end
    ld_valid = 0;
    check("full_accepted", 32'(accepted), 32'd1);
    check("full_waits",    32'(waits),    32'd4);
    alu_valid = 0;
    repeat (3) tick();

    // Starvation: one buffered load against continuous ALU traffic
    alu_valid = 1; alu_rd = 6; alu_result = 32'h66;
    ld_valid = 1; ld_rd = 9; ld_funct3 = 3'b010; ld_data = 32'h99;
    tick();
    ld_valid = 0;
    waits = 0;
    for (int i = 0; i < 10; i++) begin
      if (!alu_ready) break;
      waits++;
      tick();
    end
    check("starve_alu_wins", 32'(waits), 32'd4);
    tick();
    check("starve_ld_en",   32'(WR_EN),        32'd1);
    check("starve_ld_sel",  32'(write_select), 32'd9);
    check("starve_ld_data", data_in,           32'h99);
    check("starve_resume",  32'(alu_ready),    32'd1);
    tick();
    check("starve_alu_back", 32'(write_select), 32'd6);
    alu_valid = 0;
    tick();

    // Hazard query and reset with buffered loads
    alu_valid = 1; alu_rd = 1;
    ld_valid = 1; ld_rd = 7; ld_funct3 = 3'b010;
    tick();
    ld_rd = 8;
    tick();
    ld_valid = 0;
    hz_rs1 = 0; hz_rs2 = 7;
    #1 check("hz_rs2_hit", 32'(hz_stall), 32'd1);
    hz_rs1 = 8; hz_rs2 = 0;
    #1 check("hz_rs1_hit", 32'(hz_stall), 32'd1);
    hz_rs1 = 3; hz_rs2 = 0;
    #1 check("hz_miss",    32'(hz_stall), 32'd0);
    hz_rs2 = 7;
    rst = 1; alu_valid = 0;
    tick();
    rst = 0;
    check("rst_hz",       32'(hz_stall), 32'd0);
    check("rst_wr_en",    32'(WR_EN),    32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_no_write", 32'(WR_EN), 32'd0);
    end

    // Mixed traffic sweep, checked by the model every cycle
    for (int i = 0; i < 96; i++) begin
      alu_valid  = (i % 4) != 1;
      alu_rd     = 5'(i % 8);
      alu_result = 32'h1000_0000 + 32'(i);
      ld_valid   = (i % 3) != 2;
      ld_rd      = 5'((i * 5) % 32);
      ld_funct3  = 3'(i);
      ld_addr_lo = 2'(i / 8);
      ld_data    = 32'h80FF_7F01 ^ (32'(i) * 32'h0101_0101);
      hz_rs1     = 5'(i % 8);
      hz_rs2     = 5'((i * 7) % 32);
      tick();
    end
    idle_inputs();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
